// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that funnels several request channels onto a single
// downstream memory port, keeping exactly one transaction outstanding and
// completing it with either the memory response or a timeout error.
module mem_bus_arbiter #(
    parameter int NUM_CHANNELS   = 4,
    parameter int ADDR_W         = 21,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int CH_W          = (NUM_CHANNELS > 2) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CHANNELS-1:0]        req_valid,
    input  logic [NUM_CHANNELS-1:0]        req_write,
    input  logic [NUM_CHANNELS*ADDR_W-1:0] req_addr,
    input  logic [NUM_CHANNELS*DATA_W-1:0] req_wdata,
    output logic [NUM_CHANNELS-1:0]        req_ready,
    output logic [NUM_CHANNELS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           rsp_error,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_write,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic                           mem_rsp_valid,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic                           busy,
    output logic [CH_W-1:0]                grant_id,
    output logic                           stray_rsp
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [CH_W-1:0]   sel_idx;
    logic [CH_W-1:0]   next_ptr;
    logic              sel_found;
    logic              accept;
    logic              rsp_hit;
    logic              tmo_hit;
    logic [15:0]       tmo_cnt_q;

    // Pick the first pending channel at or after the round-robin pointer;
    // scanning from the far end lets the nearest hit overwrite the others.
    always_comb begin : select_blk
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_CHANNELS;
            if (req_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = CH_W'(idx);
            end
        end
    end

    // A new request is taken only in IDLE and never in the cycle the
    // previous completion is still being pulsed back to its channel.
    assign accept    = (state_q == IDLE) && !(|rsp_valid) && sel_found;
    assign req_ready = (accept && rst_n) ? (NUM_CHANNELS'(1) << sel_idx) : '0;

    assign rsp_hit  = (state_q == WAIT_RSP) && mem_rsp_valid;
    assign tmo_hit  = (state_q == WAIT_RSP) && !mem_rsp_valid &&
                      (tmo_cnt_q == 16'(TIMEOUT_CYCLES));
    assign next_ptr = (grant_id == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_id + 1'b1;

    assign busy          = (state_q != IDLE);
    assign mem_req_valid = (state_q == ISSUE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the single-outstanding transaction sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = ISSUE;
            ISSUE:    if (mem_req_ready) state_d = WAIT_RSP;
            WAIT_RSP: if (rsp_hit || tmo_hit) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Capture the winning channel's request so it stays stable downstream
    // even if the channel drops its request afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant_id  <= '0;
        end else if (accept) begin
            mem_write <= req_write[sel_idx];
            mem_addr  <= req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[int'(sel_idx)*DATA_W +: DATA_W];
            grant_id  <= sel_idx;
        end
    end

    // Completion pulse back to the owning channel; a response in the same
    // cycle as expiry wins over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            rr_ptr_q  <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            if (rsp_hit) begin
                rsp_valid <= NUM_CHANNELS'(1) << grant_id;
                rsp_rdata <= mem_write ? '0 : mem_rdata;
                rr_ptr_q  <= next_ptr;
            end else if (tmo_hit) begin
                rsp_valid <= NUM_CHANNELS'(1) << grant_id;
                rsp_error <= 1'b1;
                rr_ptr_q  <= next_ptr;
            end
        end
    end

    // Timeout counter: restarted as the request is handed off, then counts
    // every response-less cycle spent waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ISSUE && mem_req_ready) begin
            tmo_cnt_q <= '0;
        end else if (rsp_hit || tmo_hit) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WAIT_RSP) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    // Sticky flag for memory responses arriving when none is expected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stray_rsp <= 1'b0;
        end else if (mem_rsp_valid && state_q != WAIT_RSP) begin
            stray_rsp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter: reset, round-robin order, read,
// write acknowledge, backpressure, timeout, response-at-expiry, stray
// response and reset in the middle of a transaction.
module tb_mem_bus_arbiter;

    localparam int NCH  = 4;
    localparam int AW   = 21;
    localparam int DW   = 64;
    localparam int TMO  = 8;
    localparam int CHW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_write;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_error;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_write;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rdata;
    logic              busy;
    logic [CHW-1:0]    grant_id;
    logic              stray_rsp;

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arbiter #(
        .NUM_CHANNELS  (NCH),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .grant_id     (grant_id),
        .stray_rsp    (stray_rsp)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] valid, input logic [NCH-1:0] write);
        req_valid = valid;
        req_write = write;
        #1;
    endtask

    // One full transaction with every channel requesting; exp_ch is the
    // hand-derived round-robin winner.
    task automatic roundRobinStep(input int exp_ch, input logic [DW-1:0] data);
        checkOutput("rr_ready", req_ready, 64'(4'b0001 << exp_ch));
        tick();
        checkOutput("rr_grant", grant_id, 64'(exp_ch));
        tick();
        mem_rsp_valid = 1'b1;
        mem_rdata     = data;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("rr_rsp_valid", rsp_valid, 64'(4'b0001 << exp_ch));
        checkOutput("rr_rdata", rsp_rdata, data);
        checkOutput("rr_no_accept_in_rsp", req_ready, 64'd0);
        tick();
    endtask

    // Directed sequence.
    initial begin
        int n;
        rst_n         = 1'b0;
        req_valid     = 4'b1111;
        req_write     = '0;
        req_addr      = '0;
        req_wdata     = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;

        // Reset state with all channels requesting.
        tick();
        tick();
        checkOutput("rst_req_ready", req_ready, 64'd0);
        checkOutput("rst_busy", busy, 64'd0);
        checkOutput("rst_mem_req_valid", mem_req_valid, 64'd0);
        checkOutput("rst_rsp_valid", rsp_valid, 64'd0);
        checkOutput("rst_grant", grant_id, 64'd0);
        checkOutput("rst_stray", stray_rsp, 64'd0);
        rst_n = 1'b1;
        #1;

        // Round-robin order 0,1,2,3,0.
        roundRobinStep(0, 64'h1111);
        roundRobinStep(1, 64'h2222);
        roundRobinStep(2, 64'h3333);
        roundRobinStep(3, 64'h4444);
        roundRobinStep(0, 64'h5555);

        // Single read from channel 2, response three cycles later.
        req_addr[2*AW +: AW] = 21'h01000;
        applyStimulus(4'b0100, 4'b0000);
        checkOutput("rd_ready", req_ready, 64'h4);
        tick();
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("rd_mem_valid", mem_req_valid, 64'd1);
        checkOutput("rd_mem_addr", mem_addr, 64'h1000);
        checkOutput("rd_mem_write", mem_write, 64'd0);
        checkOutput("rd_grant", grant_id, 64'd2);
        checkOutput("rd_busy", busy, 64'd1);
        tick();
        checkOutput("rd_mem_valid_wait", mem_req_valid, 64'd0);
        tick();
        tick();
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hDEADBEEF;
        tick();
        mem_rsp_valid = 1'b0;
        applyStimulus(4'b1011, 4'b0000);
        checkOutput("rd_rsp_valid", rsp_valid, 64'h4);
        checkOutput("rd_rsp_rdata", rsp_rdata, 64'hDEADBEEF);
        checkOutput("rd_rsp_error", rsp_error, 64'd0);
        checkOutput("rd_busy_done", busy, 64'd0);
        checkOutput("rd_no_accept_in_rsp", req_ready, 64'd0);
        tick();
        checkOutput("rd_rsp_pulse_end", rsp_valid, 64'd0);
        checkOutput("rd_next_ptr_ch3", req_ready, 64'h8);
        applyStimulus(4'b0000, 4'b0000);
        tick();

        // Write acknowledge from channel 0 (pointer wraps from 3).
        req_addr[0 +: AW]  = 21'h00020;
        req_wdata[0 +: DW] = 64'h55;
        applyStimulus(4'b0001, 4'b0001);
        checkOutput("wr_ready", req_ready, 64'h1);
        tick();
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("wr_mem_write", mem_write, 64'd1);
        checkOutput("wr_mem_addr", mem_addr, 64'h20);
        checkOutput("wr_mem_wdata", mem_wdata, 64'h55);
        checkOutput("wr_grant", grant_id, 64'd0);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("wr_rsp_valid", rsp_valid, 64'h1);
        checkOutput("wr_rsp_rdata", rsp_rdata, 64'd0);
        checkOutput("wr_rsp_error", rsp_error, 64'd0);
        tick();

        // Backpressure: memory not ready for five cycles.
        mem_req_ready = 1'b0;
        req_addr[1*AW +: AW]  = 21'h1ABCD;
        req_wdata[1*DW +: DW] = 64'h0123456789ABCDEF;
        applyStimulus(4'b0010, 4'b0010);
        checkOutput("bp_ready", req_ready, 64'h2);
        tick();
        applyStimulus(4'b0110, 4'b0010);
        for (int i = 1; i <= 5; i++) begin
            checkOutput("bp_mem_valid", mem_req_valid, 64'd1);
            checkOutput("bp_mem_addr", mem_addr, 64'h1ABCD);
            checkOutput("bp_mem_wdata", mem_wdata, 64'h0123456789ABCDEF);
            checkOutput("bp_no_ready_issue", req_ready, 64'd0);
            tick();
        end
        applyStimulus(4'b0000, 4'b0010);
        mem_req_ready = 1'b1;
        checkOutput("bp_mem_valid_c6", mem_req_valid, 64'd1);
        tick();
        checkOutput("bp_handed_off", mem_req_valid, 64'd0);
        checkOutput("bp_busy_wait", busy, 64'd1);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        req_write     = '0;
        #1;
        checkOutput("bp_rsp_valid", rsp_valid, 64'h2);
        checkOutput("bp_rsp_rdata", rsp_rdata, 64'd0);
        tick();

        // Timeout on a channel 3 read with no response.
        mem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
        applyStimulus(4'b1000, 4'b0000);
        checkOutput("to_ready", req_ready, 64'h8);
        tick();
        applyStimulus(4'b0000, 4'b0000);
        tick();
        n = 0;
        while (rsp_valid == '0 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("to_cycles", 64'(n), 64'(TMO + 1));
        checkOutput("to_rsp_valid", rsp_valid, 64'h8);
        checkOutput("to_rsp_error", rsp_error, 64'd1);
        checkOutput("to_rsp_rdata", rsp_rdata, 64'd0);
        checkOutput("to_idle", busy, 64'd0);
        tick();
        checkOutput("to_pulse_end", rsp_valid, 64'd0);
        checkOutput("to_error_end", rsp_error, 64'd0);

        // Response arriving in the same cycle the timeout would expire.
        applyStimulus(4'b0001, 4'b0000);
        tick();
        applyStimulus(4'b0000, 4'b0000);
        tick();
        for (int i = 0; i < TMO; i++) tick();
        checkOutput("ex_still_waiting", busy, 64'd1);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'h1234;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("ex_rsp_valid", rsp_valid, 64'h1);
        checkOutput("ex_rsp_error", rsp_error, 64'd0);
        checkOutput("ex_rsp_rdata", rsp_rdata, 64'h1234);
        checkOutput("ex_no_stray", stray_rsp, 64'd0);
        tick();

        // Stray response while idle.
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("st_stray", stray_rsp, 64'd1);
        checkOutput("st_no_rsp", rsp_valid, 64'd0);
        tick();
        checkOutput("st_sticky", stray_rsp, 64'd1);

        // Reset asserted while waiting for a response.
        applyStimulus(4'b0010, 4'b0000);
        tick();
        tick();
        checkOutput("mr_busy_before", busy, 64'd1);
        checkOutput("mr_ready_before", req_ready, 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_busy", busy, 64'd0);
        checkOutput("mr_req_ready", req_ready, 64'd0);
        checkOutput("mr_stray", stray_rsp, 64'd0);
        checkOutput("mr_mem_valid", mem_req_valid, 64'd0);
        checkOutput("mr_grant", grant_id, 64'd0);
        checkOutput("mr_mem_addr", mem_addr, 64'd0);
        checkOutput("mr_rsp_valid", rsp_valid, 64'd0);
        applyStimulus(4'b0000, 4'b0000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("mr_late_no_rsp", rsp_valid, 64'd0);
        checkOutput("mr_late_stray", stray_rsp, 64'd1);
        checkOutput("mr_late_idle", busy, 64'd0);
        tick();
        checkOutput("mr_late_no_rsp2", rsp_valid, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
